// File: rtl/spi_cmd_ctrl.sv
// SPI byte-stream command controller: loads two interleaved BRAMs, kicks the HLS
// core, reports status and returns BRAM contents or HLS results byte by byte.
module spi_cmd_ctrl #(
    parameter int BRAM_WIDTH  = 32,
    parameter int BRAM_DEPTH  = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_valid,
    input  logic [7:0]                    i_rx_data,
    output logic [7:0]                    o_tx_data,
    output logic [$clog2(BRAM_DEPTH)-1:0] o_bram_addr,
    output logic [BRAM_WIDTH-1:0]         o_bram_wdata,
    output logic                          o_bram_we_a,
    output logic                          o_bram_we_b,
    input  logic [BRAM_WIDTH-1:0]         i_bram_rdata_a,
    input  logic [BRAM_WIDTH-1:0]         i_bram_rdata_b,
    output logic                          o_hls_start,
    input  logic                          i_hls_done,
    input  logic [BRAM_WIDTH-1:0]         i_result1,
    input  logic [BRAM_WIDTH-1:0]         i_result2
);
    localparam int NWORDS = 2 * BRAM_DEPTH;
    localparam int WIW    = $clog2(NWORDS);
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA, RES_OUT} state_t;
    state_t state_q, state_d;

    logic [1:0]            byte_idx;
    logic [WIW-1:0]        word_idx, word_nxt;
    logic [23:0]           wr_shift;
    logic [BRAM_WIDTH-1:0] rd_word, res_word, result1_q, result2_q;
    logic                  res_sel, done_flag, start_pend;
    logic [1:0]            vld_pipe;
    logic [TW-1:0]         tout_cnt;
    logic                  last_byte, last_word, timeout;

    assign word_nxt  = word_idx + WIW'(1);
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_idx == WIW'(NWORDS - 1));
    assign timeout   = (state_q != IDLE) && !i_rx_valid && (tout_cnt == TW'(TIMEOUT_CYC - 1));
    assign res_word  = res_sel ? result2_q : result1_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        o_tx_data = 8'h00;
        case (state_q)
            IDLE: begin
                o_tx_data = {7'b0, done_flag};
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h01:        state_d = WR_DATA;
                        8'h02:        state_d = RD_DATA;
                        8'h04, 8'h05: state_d = RES_OUT;
                        default:      state_d = IDLE;
                    endcase
                end
            end
            WR_DATA: begin
                if (i_rx_valid && last_byte && last_word) state_d = IDLE;
            end
            RD_DATA: begin
                o_tx_data = rd_word[{byte_idx, 3'b000} +: 8];
                if (i_rx_valid && last_byte && last_word) state_d = IDLE;
            end
            RES_OUT: begin
                o_tx_data = res_word[{byte_idx, 3'b000} +: 8];
                if (i_rx_valid && last_byte) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx     <= '0;
            word_idx     <= '0;
            wr_shift     <= '0;
            rd_word      <= '0;
            result1_q    <= '0;
            result2_q    <= '0;
            res_sel      <= 1'b0;
            done_flag    <= 1'b0;
            start_pend   <= 1'b0;
            vld_pipe     <= '0;
            tout_cnt     <= '0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            o_bram_we_a  <= 1'b0;
            o_bram_we_b  <= 1'b0;
            o_hls_start  <= 1'b0;
        end else begin
            o_bram_we_a <= 1'b0;
            o_bram_we_b <= 1'b0;
            start_pend  <= 1'b0;
            o_hls_start <= start_pend;
            // addr registered at stage 0, BRAM read data valid one cycle later
            vld_pipe    <= {vld_pipe[0], 1'b0};
            if (vld_pipe[1]) rd_word <= word_idx[0] ? i_bram_rdata_b : i_bram_rdata_a;

            if (i_rx_valid || state_q == IDLE) tout_cnt <= '0;
            else                               tout_cnt <= tout_cnt + TW'(1);

            case (state_q)
                IDLE: begin
                    if (i_rx_valid) begin
                        byte_idx <= '0;
                        word_idx <= '0;
                        if (i_rx_data == 8'h02) begin
                            o_bram_addr <= '0;
                            vld_pipe[0] <= 1'b1;
                        end
                        if (i_rx_data == 8'h04 || i_rx_data == 8'h05)
                            res_sel <= (i_rx_data == 8'h05);
                    end
                end
                WR_DATA: begin
                    if (i_rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            o_bram_wdata <= {i_rx_data, wr_shift};
                            o_bram_addr  <= word_idx[WIW-1:1];
                            o_bram_we_a  <= !word_idx[0];
                            o_bram_we_b  <= word_idx[0];
                            word_idx     <= word_nxt;
                            if (last_word) start_pend <= 1'b1;
                        end else begin
                            wr_shift[{byte_idx, 3'b000} +: 8] <= i_rx_data;
                        end
                    end
                end
                RD_DATA: begin
                    if (i_rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte && !last_word) begin
                            word_idx    <= word_nxt;
                            o_bram_addr <= word_nxt[WIW-1:1];
                            vld_pipe[0] <= 1'b1;
                        end
                    end
                end
                RES_OUT: begin
                    if (i_rx_valid) byte_idx <= byte_idx + 2'd1;
                end
                default: ;
            endcase

            if (timeout) begin
                byte_idx <= '0;
                word_idx <= '0;
            end

            // a completion landing on the start-pulse cycle must win
            if (i_hls_done) begin
                done_flag <= 1'b1;
                result1_q <= i_result1;
                result2_q <= i_result2;
            end else if (o_hls_start) begin
                done_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed-sequence bench with randomized payloads; expected bytes come from a
// word-array / result model, BRAMs are modelled as simple 1-cycle-latency memories.
module tb_spi_cmd_ctrl;
    localparam int DEPTH = 10;
    localparam int NW    = 2 * DEPTH;
    localparam int TOUT  = 64;
    localparam int GAP   = 6;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata_a, rdata_b;
    logic        we_a, we_b, start;
    logic        hls_done = 1'b0;
    logic [31:0] result1 = '0, result2 = '0;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.BRAM_WIDTH(32), .BRAM_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_tx_data(tx), .o_bram_addr(addr), .o_bram_wdata(wdata),
        .o_bram_we_a(we_a), .o_bram_we_b(we_b),
        .i_bram_rdata_a(rdata_a), .i_bram_rdata_b(rdata_b),
        .o_hls_start(start), .i_hls_done(hls_done),
        .i_result1(result1), .i_result2(result2)
    );

    typedef struct packed {
        logic        wa;
        logic        wb;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         obs_wr[$];
    int          obs_start = 0;
    logic [31:0] mem_a[16], mem_b[16];
    logic [31:0] w[NW];
    logic [31:0] r1_m = '0, r2_m = '0;
    logic        done_m = 1'b0;
    int          checks = 0, errors = 0;

    always @(posedge clk) begin
        if (we_a) mem_a[addr] <= wdata;
        if (we_b) mem_b[addr] <= wdata;
        rdata_a <= mem_a[addr];
        rdata_b <= mem_b[addr];
    end

    always @(negedge clk) begin
        if (we_a || we_b) obs_wr.push_back('{we_a, we_b, addr, wdata});
        if (start) obs_start++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns the byte the slave would shift out during this transfer
    task automatic send_byte(input logic [7:0] b, input int gap, output logic [7:0] seen);
        seen     = tx;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic status(input string tag);
        logic [7:0] s;
        send_byte(8'h03, GAP, s);
        chk(tag, {24'h0, s}, {31'h0, done_m});
    endtask

    task automatic pulse_done(input logic [31:0] r1, input logic [31:0] r2);
        hls_done = 1'b1; result1 = r1; result2 = r2;
        @(negedge clk);
        hls_done = 1'b0;
        r1_m = r1; r2_m = r2; done_m = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic res_read(input logic sel);
        logic [7:0]  s;
        logic [31:0] r;
        r = sel ? r2_m : r1_m;
        send_byte(sel ? 8'h05 : 8'h04, GAP, s);
        chk("res_cmd_status", {24'h0, s}, {31'h0, done_m});
        for (int b = 0; b < 4; b++) begin
            send_byte(8'($urandom_range(1, 5)), GAP, s);
            chk(sel ? "res2_byte" : "res1_byte", {24'h0, s}, {24'h0, r[8*b +: 8]});
        end
    endtask

    task automatic do_write(input bit coincide);
        logic [7:0] s;
        int  base, st;
        bit  seen;
        wr_t e;
        base = obs_wr.size();
        st   = obs_start;
        seen = 1'b0;
        for (int k = 0; k < NW; k++) w[k] = $urandom;
        send_byte(8'h01, GAP, s);
        chk("wr_cmd_status", {24'h0, s}, {31'h0, done_m});
        for (int k = 0; k < NW; k++)
            for (int b = 0; b < 4; b++)
                send_byte(w[k][8*b +: 8], (k == NW-1 && b == 3) ? 0 : GAP, s);
        for (int i = 0; i < 8; i++) begin
            if (coincide && !seen && start) begin
                seen = 1'b1;
                hls_done = 1'b1; result1 = $urandom; result2 = $urandom;
            end
            @(negedge clk);
            hls_done = 1'b0;
        end
        if (coincide) begin
            chk("start_for_coincide", {31'h0, seen}, 32'h1);
            r1_m = result1; r2_m = result2; done_m = 1'b1;
        end else begin
            done_m = 1'b0;
        end
        chk("wr_strobe_count", obs_wr.size() - base, NW);
        chk("start_count", obs_start - st, 1);
        for (int k = 0; k < NW && base + k < obs_wr.size(); k++) begin
            e = obs_wr[base + k];
            chk("wr_side", {30'h0, e.wa, e.wb}, (k % 2) ? 32'h1 : 32'h2);
            chk("wr_addr", {28'h0, e.addr}, k / 2);
            chk("wr_data", e.data, w[k]);
        end
    endtask

    task automatic readback();
        logic [7:0] s;
        int base;
        base = obs_wr.size();
        send_byte(8'h02, GAP, s);
        chk("rd_cmd_status", {24'h0, s}, {31'h0, done_m});
        for (int k = 0; k < NW; k++)
            for (int b = 0; b < 4; b++) begin
                send_byte(8'($urandom_range(1, 5)), GAP, s);
                chk("rd_byte", {24'h0, s}, {24'h0, w[k][8*b +: 8]});
            end
        chk("rd_no_strobe", obs_wr.size() - base, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        int base, st;

        repeat (3) @(negedge clk);
        chk("rst_tx", {24'h0, tx}, 0);
        chk("rst_addr", {28'h0, addr}, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_we", {30'h0, we_a, we_b}, 0);
        chk("rst_start", {31'h0, start}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        status("status_before_done");
        do_write(1'b0);
        status("status_after_write");

        pulse_done(32'h12345678, $urandom);
        status("status_after_done");
        res_read(1'b0);
        res_read(1'b1);
        readback();
        status("status_after_read");

        do_write(1'b1);
        status("status_done_wins");
        res_read(1'b0);
        do_write(1'b0);
        status("status_cleared_by_start");
        readback();

        // partial word then silence: must be dropped
        base = obs_wr.size();
        send_byte(8'h01, GAP, s);
        for (int b = 0; b < 3; b++) send_byte(8'(b + 1), GAP, s);
        repeat (TOUT + 10) @(negedge clk);
        chk("timeout_no_strobe", obs_wr.size() - base, 0);
        send_byte(8'h7F, GAP, s);
        chk("unknown_cmd_status", {24'h0, s}, {31'h0, done_m});
        res_read(1'b0);
        chk("timeout_still_no_strobe", obs_wr.size() - base, 0);

        // reset in the middle of word 7
        pulse_done($urandom, $urandom);
        status("status_before_reset");
        base = obs_wr.size();
        send_byte(8'h01, GAP, s);
        for (int i = 0; i < 7 * 4 + 2; i++) send_byte(8'($urandom), GAP, s);
        chk("pre_reset_strobes", obs_wr.size() - base, 7);
        base = obs_wr.size();
        st   = obs_start;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {24'h0, tx}, 0);
        chk("midrst_addr", {28'h0, addr}, 0);
        chk("midrst_wdata", wdata, 0);
        chk("midrst_we", {30'h0, we_a, we_b}, 0);
        chk("midrst_start", {31'h0, start}, 0);
        done_m = 1'b0; r1_m = '0; r2_m = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(8'h55, GAP, s);
        chk("post_reset_no_strobe", obs_wr.size() - base, 0);
        chk("post_reset_no_start", obs_start - st, 0);
        status("status_after_reset");
        res_read(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter BRAM_WIDTH, default 32, word width (fixed at 32 in this block: 4 bytes per word).
REQ-002 SHALL have parameter BRAM_DEPTH, default 10, entries per BRAM; 2*BRAM_DEPTH words per transfer.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, idle cycles before an open command is aborted.
REQ-004 SHALL have port i_clk, input, 1, sole clock (one clock, no other clock domains).
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_rx_valid, input, 1, one-cycle pulse per byte received from the SPI slave.
REQ-007 SHALL have port i_rx_data, input, 8, received byte, valid with i_rx_valid.
REQ-008 SHALL have port o_tx_data, output, 8, byte the SPI slave shifts out on the next byte transfer.
REQ-009 SHALL have port o_bram_addr, output, $clog2(BRAM_DEPTH), shared BRAM address.
REQ-010 SHALL have port o_bram_wdata, output, 32, BRAM write data.
REQ-011 SHALL have ports o_bram_we_a and o_bram_we_b, outputs, 1 each, write strobes for BRAM A and BRAM B.
REQ-012 SHALL have ports i_bram_rdata_a and i_bram_rdata_b, inputs, 32 each, read data with 1-cycle latency from o_bram_addr.
REQ-013 SHALL have port o_hls_start, output, 1, one-cycle start pulse to the HLS core.
REQ-014 SHALL have port i_hls_done, input, 1, one-cycle completion pulse from the HLS core.
REQ-015 SHALL have ports i_result1 and i_result2, inputs, 32 each, HLS results, valid in the i_hls_done cycle.

Function
REQ-016 SHALL implement FSM states IDLE, WR_DATA, RD_DATA, RES_OUT.
REQ-017 SHALL treat a byte received in IDLE as a command: 0x01 -> WR_DATA; 0x02 -> RD_DATA; 0x03 -> stay IDLE; 0x04/0x05 -> RES_OUT selecting result1/result2; any other value -> ignored, stay IDLE.
REQ-018 SHALL drive o_tx_data = {7'b0, done_flag} while in IDLE, so the status is returned during any command byte.
REQ-019 SHALL in WR_DATA assemble bytes LSB first into a word; on the 4th byte assert o_bram_wdata and the strobe for exactly 1 cycle, within 2 cycles of that i_rx_valid.
REQ-020 SHALL map word index k (0..2*BRAM_DEPTH-1) to BRAM A when k is even and BRAM B when k is odd, with o_bram_addr = k/2.
REQ-021 SHALL after writing word 2*BRAM_DEPTH-1 pulse o_hls_start for 1 cycle, clear done_flag, and return to IDLE.
REQ-022 SHALL in RD_DATA prefetch word 0 on command entry, and after each byte present the next byte (LSB first, same A/B mapping) on o_tx_data within 4 cycles of i_rx_valid; after byte 8*BRAM_DEPTH-1 return to IDLE.
REQ-023 SHALL in RES_OUT present the latched result LSB first, one byte per i_rx_valid, and return to IDLE after 4 bytes.
REQ-024 SHALL ignore received byte values in WR_DATA/RD_DATA/RES_OUT for command decoding (0x01..0x05 there are data).
REQ-025 SHALL on i_hls_done set done_flag and latch i_result1/i_result2 into internal registers.
REQ-026 SHALL give i_hls_done priority when it coincides with the o_hls_start clear: done_flag ends at 1.
REQ-027 SHALL count cycles without i_rx_valid in any non-IDLE state, and at TIMEOUT_CYC return to IDLE, discarding any partial word (no write strobe).
REQ-028 SHALL keep o_bram_we_a and o_bram_we_b deasserted in all states other than the REQ-019 strobe cycle.

Reset
REQ-029 SHALL on i_rst_n low asynchronously enter IDLE and set: o_tx_data=0x00, strobes=0, o_hls_start=0, o_bram_addr=0, o_bram_wdata=0, done_flag=0, result registers=0, word/byte counters=0, timeout counter=0.
REQ-030 SHALL on reset asserted mid-command abandon the command with no write strobe or start pulse issued after reset assertion.

Verification
REQ-031 SHALL verify write: send 0x01 then 80 bytes for words 1,10,2,20,...,100,10 -> 20 strobes, A gets 1..5,60..100 at addr 0..9, o_hls_start pulses once after the last byte.
REQ-032 SHALL verify status: 0x03 before done -> 0x00 returned; pulse i_hls_done with i_result1=0x12345678 -> next 0x03 returns 0x01; 0x04 + 4 bytes -> 0x78,0x56,0x34,0x12.
REQ-033 SHALL verify readback: 0x02 then 80 bytes -> returned words match those written, LSB first, interleaved A/B.
REQ-034 SHALL verify robustness: 0x01, 3 bytes, idle for TIMEOUT_CYC -> no strobe, IDLE; an unknown command 0x7F is ignored.
REQ-035 SHALL verify reset during WR_DATA at word 7 -> all outputs return to reset values, no further strobes, done_flag=0.
